// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage occupancy encoding and per-boundary payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  // IF/ID carries pc4 + pc + instruction + prediction.
  localparam int IFID_W  = 97;
  localparam int IDEX_W  = 180;
  localparam int EXMEM_W = 110;
  localparam int MEMWB_W = 72;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; shared by performance counters.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with two-entry skid buffer, registered in_ready and synchronous flush.
// Optional output-stall counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = IFID_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_STATS_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [WIDTH-1:0] out_data
);

  pipe_state_t      state_p0, state_nx;
  logic [WIDTH-1:0] main_p0, main_nx;
  logic [WIDTH-1:0] skid_p0, skid_nx;
  logic             in_ready_p0;
  logic             in_fire, out_fire;

  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = main_p0;
  assign in_ready  = in_ready_p0;
  assign in_fire   = in_valid & in_ready_p0;
  assign out_fire  = out_valid & out_ready;

  // Main register is cleared whenever the stage drains so a bubble reads as a zero word.
  always_comb begin
    state_nx = state_p0;
    main_nx  = main_p0;
    skid_nx  = skid_p0;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = '0;
      skid_nx  = '0;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_nx = HALF;
            main_nx  = in_data;
          end
        end
        HALF: begin
          if (in_fire && !out_fire) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (in_fire && out_fire) begin
            main_nx  = in_data;
          end else if (out_fire) begin
            state_nx = EMPTY;
            main_nx  = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nx = HALF;
            main_nx  = skid_p0;
            skid_nx  = '0;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = '0;
          skid_nx  = '0;
        end
      endcase
    end
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0    <= EMPTY;
      main_p0     <= '0;
      skid_p0     <= '0;
      in_ready_p0 <= 1'b0;
    end else begin
      state_p0    <= state_nx;
      main_p0     <= main_nx;
      skid_p0     <= skid_nx;
      in_ready_p0 <= (state_nx != FULL);
    end
  end

`ifdef PIPE_SKID_STATS_EN
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed, table-driven bench for pipe_skid_reg plus hand-written reset and stats sequences.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int W  = IFID_W;
  localparam int CW = 4;
  localparam int NV = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
  } vec_t;

  vec_t vt[NV];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPE_SKID_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .out_data  (out_data)
  );

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                              input logic fl, input logic ov, input logic [W-1:0] od,
                              input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    logic [W-1:0] wide;
    wide = {1'b1, 96'h0000_0000_0000_0000_0000_0030};

    //        iv    data      ordy  fl    ov    out_data  ir
    vt[0]  = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);
    vt[1]  = mk(1'b1, 'h1,    1'b1, 1'b0, 1'b1, 'h1,    1'b1);
    vt[2]  = mk(1'b1, 'h2,    1'b1, 1'b0, 1'b1, 'h2,    1'b1);
    vt[3]  = mk(1'b1, 'h3,    1'b1, 1'b0, 1'b1, 'h3,    1'b1);
    vt[4]  = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);
    vt[5]  = mk(1'b1, 'hA,    1'b0, 1'b0, 1'b1, 'hA,    1'b1);
    vt[6]  = mk(1'b1, 'hB,    1'b0, 1'b0, 1'b1, 'hA,    1'b0);
    vt[7]  = mk(1'b1, 'hD,    1'b0, 1'b0, 1'b1, 'hA,    1'b0);
    vt[8]  = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b1, 'hB,    1'b1);
    vt[9]  = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);
    vt[10] = mk(1'b1, 'h10,   1'b0, 1'b0, 1'b1, 'h10,   1'b1);
    vt[11] = mk(1'b1, 'h11,   1'b0, 1'b0, 1'b1, 'h10,   1'b0);
    vt[12] = mk(1'b1, 'hC,    1'b0, 1'b1, 1'b0, 'h0,    1'b1);
    vt[13] = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);
    vt[14] = mk(1'b1, 'h20,   1'b1, 1'b0, 1'b1, 'h20,   1'b1);
    vt[15] = mk(1'b1, 'h21,   1'b1, 1'b1, 1'b0, 'h0,    1'b1);
    vt[16] = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);
    vt[17] = mk(1'b1, wide,   1'b1, 1'b0, 1'b1, wide,   1'b1);
    vt[18] = mk(1'b0, 'h0,    1'b1, 1'b0, 1'b0, 'h0,    1'b1);

    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 0, W'(out_valid), '0);
    chk("rst_out_data",  0, out_data,      '0);
    chk("rst_in_ready",  0, W'(in_ready),  '0);
`ifdef PIPE_SKID_STATS_EN
    chk("rst_stall_cnt", 0, W'(stall_cnt), '0);
`endif
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy, vt[i].fl);
      tick();
      chk("out_valid", i, W'(out_valid), W'(vt[i].ov));
      chk("out_data",  i, out_data,      vt[i].od);
      chk("in_ready",  i, W'(in_ready),  W'(vt[i].ir));
    end

    // Asynchronous reset while HALF: outputs clear with no clock edge.
    drive(1'b1, 'h40, 1'b0, 1'b0);
    tick();
    chk("half_out_data", 0, out_data, 'h40);
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 0, W'(out_valid), '0);
    chk("arst_out_data",  0, out_data,      '0);
    chk("arst_in_ready",  0, W'(in_ready),  '0);
    tick();
    rst = 1'b1;
    tick();
    chk("rel_in_ready",  0, W'(in_ready),  W'(1'b1));
    chk("rel_out_valid", 0, W'(out_valid), '0);

`ifdef PIPE_SKID_STATS_EN
    chk("stat_clear", 0, W'(stall_cnt), '0);
    drive(1'b1, 'h50, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("stat_count5", 0, W'(stall_cnt), W'(5));
    for (int k = 0; k < 15; k++) tick();
    chk("stat_sat", 0, W'(stall_cnt), W'(15));
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("stat_flush_keep", 0, W'(stall_cnt), W'(15));
    chk("stat_flush_ov",   0, W'(out_valid), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
